// File: rtl/gpio_switch_debounce_bit.sv
// One switch bit: 2-flop synchronizer, consecutive-cycle debounce counter,
// and registered rise/fall strobes that coincide with the level update.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic strobe_next_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q,  rise_d;
  logic             fall_q,  fall_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Accept the new level; the counter clears here so it can never wrap.
      level_d = sync2_q;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o       = level_q;
  assign rise_o        = rise_q;
  assign fall_o        = fall_q;
  // Next-cycle strobe lets the top register the OR alongside the per-bit strobes.
  assign strobe_next_o = rise_d | fall_d;

endmodule

// File: rtl/gpio_switch_debounce.sv
// Switch-bank conditioner: WIDTH independent debounce_bit slices plus a
// registered any-edge flag aligned with the per-bit strobes.
module gpio_switch_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             SYSTEMCLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  logic [WIDTH-1:0] strobe_next;
  logic             sw_changed_q, sw_changed_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk          (SYSTEMCLOCK),
      .rst          (RESET),
      .raw_i        (sw_raw[i]),
      .level_o      (sw_level[i]),
      .rise_o       (sw_rise[i]),
      .fall_o       (sw_fall[i]),
      .strobe_next_o(strobe_next[i])
    );
  end

  always_comb begin
    sw_changed_d = |strobe_next;
  end

  always_ff @(posedge SYSTEMCLOCK) begin
    if (RESET) begin
      sw_changed_q <= 1'b0;
    end else begin
      sw_changed_q <= sw_changed_d;
    end
  end

  assign sw_changed = sw_changed_q;

endmodule

// File: tb/tb_gpio_switch_debounce.sv
// Bench for gpio_switch_debounce: DEBOUNCE_CYCLES=4 and =1 instances share
// stimulus; a window model predicts every cycle's outputs into expected queues.
module tb_gpio_switch_debounce;

  logic       clk = 1'b0;
  logic       RESET;
  logic [3:0] sw_raw;
  logic [3:0] sw_level, sw_rise, sw_fall;
  logic       sw_changed;
  logic [3:0] d1_level, d1_rise, d1_fall;
  logic       d1_changed;

  always #5 clk = ~clk;

  gpio_switch_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .SYSTEMCLOCK(clk), .RESET(RESET), .sw_raw(sw_raw),
    .sw_level(sw_level), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .sw_changed(sw_changed)
  );

  gpio_switch_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(1)) dut_d1 (
    .SYSTEMCLOCK(clk), .RESET(RESET), .sw_raw(sw_raw),
    .sw_level(d1_level), .sw_rise(d1_rise), .sw_fall(d1_fall),
    .sw_changed(d1_changed)
  );

  wire [12:0] obs4 = {sw_changed, sw_fall, sw_rise, sw_level};
  wire [12:0] obs1 = {d1_changed, d1_fall, d1_rise, d1_level};

  // Scoreboard: {changed, fall, rise, level} per cycle.
  logic [12:0] exp_q[$];
  logic [12:0] exp1_q[$];
  logic [3:0]  hist[0:5];
  logic [3:0]  m_lvl4, m_lvl1;
  int          n_checks = 0;
  int          n_pass   = 0;

  // hist[0] is the raw value driven before this edge; hist[2..d+1] are the
  // d synchronized samples the DUT has seen by this edge.
  function automatic logic [12:0] predict(input logic [3:0] old, input int d);
    logic [3:0] nl, rise, fall;
    logic       same;
    nl = old;
    for (int b = 0; b < 4; b++) begin
      same = 1'b1;
      for (int k = 3; k <= d + 1; k++) if (hist[k][b] !== hist[2][b]) same = 1'b0;
      if (same && (hist[2][b] !== old[b])) nl[b] = hist[2][b];
    end
    rise = nl & ~old;
    fall = ~nl & old;
    return {|(rise | fall), fall, rise, nl};
  endfunction

  task automatic drive_step(input logic rst_v, input logic [3:0] raw_v);
    logic [12:0] e4, e1;
    RESET  = rst_v;
    sw_raw = raw_v;
    if (rst_v) begin
      for (int k = 0; k < 6; k++) hist[k] = '0;
      m_lvl4 = '0;
      m_lvl1 = '0;
      e4 = '0;
      e1 = '0;
    end else begin
      for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = raw_v;
      e4 = predict(m_lvl4, 4);
      e1 = predict(m_lvl1, 1);
      m_lvl4 = e4[3:0];
      m_lvl1 = e1[3:0];
    end
    exp_q.push_back(e4);
    exp1_q.push_back(e1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    int rise_cnt, rise_at;
    rise_cnt = 0;
    rise_at  = -1;
    for (int i = 0; i < 20; i++) begin
      drive_step(i < 3, (i < 12) ? 4'hF : 4'h0);
      e = exp_q.pop_front(); n_checks++;
      if (obs4 !== e) $display("FAIL reset d4 step %0d: got %h expected %h", i, obs4, e);
      else n_pass++;
      e = exp1_q.pop_front(); n_checks++;
      if (obs1 !== e) $display("FAIL reset d1 step %0d: got %h expected %h", i, obs1, e);
      else n_pass++;
      if (sw_rise == 4'hF) begin rise_cnt++; rise_at = i; end
    end
    n_checks++;
    if (rise_cnt !== 1 || rise_at !== 8)
      $display("FAIL reset_rise: got count %0d at step %0d, expected count 1 at step 8", rise_cnt, rise_at);
    else n_pass++;
  endtask

  task automatic test_clean_step();
    logic [12:0] e;
    int rise_at, d1_rise_at, fall_cnt;
    rise_at = -1; d1_rise_at = -1; fall_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive_step(1'b0, (i < 12) ? 4'h1 : 4'h0);
      e = exp_q.pop_front(); n_checks++;
      if (obs4 !== e) $display("FAIL clean_step d4 step %0d: got %h expected %h", i, obs4, e);
      else n_pass++;
      e = exp1_q.pop_front(); n_checks++;
      if (obs1 !== e) $display("FAIL clean_step d1 step %0d: got %h expected %h", i, obs1, e);
      else n_pass++;
      if (sw_rise == 4'h1 && sw_changed) rise_at = i;
      if (d1_rise == 4'h1) d1_rise_at = i;
      if (i < 12 && sw_fall != 4'h0) fall_cnt++;
    end
    n_checks++;
    if (rise_at !== 5 || fall_cnt !== 0)
      $display("FAIL clean_step_rise: got step %0d falls %0d, expected step 5 falls 0", rise_at, fall_cnt);
    else n_pass++;
    n_checks++;
    if (d1_rise_at !== 2)
      $display("FAIL d1_latency: got step %0d, expected step 2", d1_rise_at);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [12:0] e;
    logic [3:0]  raw;
    int early_strobes, rise_at;
    early_strobes = 0; rise_at = -1;
    for (int i = 0; i < 30; i++) begin
      raw = (i < 3 || (i >= 10 && i < 14)) ? 4'h2 : 4'h0;
      drive_step(1'b0, raw);
      e = exp_q.pop_front(); n_checks++;
      if (obs4 !== e) $display("FAIL glitch d4 step %0d: got %h expected %h", i, obs4, e);
      else n_pass++;
      e = exp1_q.pop_front(); n_checks++;
      if (obs1 !== e) $display("FAIL glitch d1 step %0d: got %h expected %h", i, obs1, e);
      else n_pass++;
      if (i < 10 && (sw_changed || sw_level != 4'h0)) early_strobes++;
      if (sw_rise == 4'h2) rise_at = i;
    end
    n_checks++;
    if (early_strobes !== 0 || rise_at !== 15)
      $display("FAIL glitch_reject: got early %0d rise step %0d, expected early 0 rise step 15", early_strobes, rise_at);
    else n_pass++;
  endtask

  task automatic test_bounce();
    logic [12:0] e;
    logic [3:0]  raw;
    int rise_cnt, rise_at;
    rise_cnt = 0; rise_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (i < 20) raw = ((i / 2) % 2 == 0) ? 4'h4 : 4'h0;
      else raw = (i < 30) ? 4'h4 : 4'h0;
      drive_step(1'b0, raw);
      e = exp_q.pop_front(); n_checks++;
      if (obs4 !== e) $display("FAIL bounce d4 step %0d: got %h expected %h", i, obs4, e);
      else n_pass++;
      e = exp1_q.pop_front(); n_checks++;
      if (obs1 !== e) $display("FAIL bounce d1 step %0d: got %h expected %h", i, obs1, e);
      else n_pass++;
      if (sw_rise[2]) begin rise_cnt++; rise_at = i; end
    end
    n_checks++;
    if (rise_cnt !== 1 || rise_at !== 25)
      $display("FAIL bounce_rise: got count %0d at step %0d, expected count 1 at step 25", rise_cnt, rise_at);
    else n_pass++;
  endtask

  task automatic test_multi_bit();
    logic [12:0] e;
    logic [3:0]  raw;
    int swap_at;
    swap_at = -1;
    for (int i = 0; i < 30; i++) begin
      raw = (i < 10) ? 4'h5 : ((i < 20) ? 4'hA : 4'h0);
      drive_step(1'b0, raw);
      e = exp_q.pop_front(); n_checks++;
      if (obs4 !== e) $display("FAIL multi_bit d4 step %0d: got %h expected %h", i, obs4, e);
      else n_pass++;
      e = exp1_q.pop_front(); n_checks++;
      if (obs1 !== e) $display("FAIL multi_bit d1 step %0d: got %h expected %h", i, obs1, e);
      else n_pass++;
      if (sw_rise == 4'hA && sw_fall == 4'h5 && sw_changed && sw_level == 4'hA) swap_at = i;
    end
    n_checks++;
    if (swap_at !== 15)
      $display("FAIL multi_bit_swap: got step %0d, expected step 15", swap_at);
    else n_pass++;
  endtask

  task automatic test_mid_count_reset();
    logic [12:0] e;
    int early_strobes, rise_at;
    early_strobes = 0; rise_at = -1;
    for (int i = 0; i < 24; i++) begin
      drive_step(i == 4 || i == 5, (i < 16) ? 4'h8 : 4'h0);
      e = exp_q.pop_front(); n_checks++;
      if (obs4 !== e) $display("FAIL mid_reset d4 step %0d: got %h expected %h", i, obs4, e);
      else n_pass++;
      e = exp1_q.pop_front(); n_checks++;
      if (obs1 !== e) $display("FAIL mid_reset d1 step %0d: got %h expected %h", i, obs1, e);
      else n_pass++;
      if (i <= 5 && (sw_changed || sw_level != 4'h0)) early_strobes++;
      if (sw_rise == 4'h8) rise_at = i;
    end
    n_checks++;
    if (early_strobes !== 0 || rise_at !== 11)
      $display("FAIL mid_reset_rise: got early %0d rise step %0d, expected early 0 rise step 11", early_strobes, rise_at);
    else n_pass++;
  endtask

  initial begin
    RESET  = 1'b1;
    sw_raw = 4'h0;
    for (int k = 0; k < 6; k++) hist[k] = '0;
    m_lvl4 = '0;
    m_lvl1 = '0;
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_multi_bit();
    test_mid_count_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_switch_debounce.md
Name: gpio_switch_debounce

Overview:
- Conditions the raw board switch bank before the switches reach the top-level LED/switch logic (the gpio_switch consumer in main).
- Per bit: 2-flop synchronizer, then a consecutive-cycle debounce counter, then a rise/fall edge detector.
- Outputs a clean debounced level plus single-cycle edge strobes in the SYSTEMCLOCK domain.

Parameters:
- WIDTH, 4, number of switch bits.
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronized input must differ from the stable value before it is accepted (about 10 ms at 100 MHz). Legal range is 1 to 2^24-1; benches override it to a small value.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width. Derived; do not override.

Ports:
- SYSTEMCLOCK  in   1      sole clock; all flops are rising-edge.
- RESET        in   1      synchronous, active-high reset.
- sw_raw       in   WIDTH  asynchronous raw switch inputs.
- sw_level     out  WIDTH  debounced stable level.
- sw_rise      out  WIDTH  one-cycle pulse when sw_level bit goes 0->1.
- sw_fall      out  WIDTH  one-cycle pulse when sw_level bit goes 1->0.
- sw_changed   out  1      OR of (sw_rise | sw_fall), registered with them in the same cycle.

Behaviour:
- Reset (RESET high at a rising edge):
  - sync_q1, sync_q2, sw_level, sw_rise, sw_fall, sw_changed and all counters go to 0.
  - Reset dominates every other condition.
- Synchronizer: sync_q1 <= sw_raw; sync_q2 <= sync_q1. Only sync_q2 is used downstream.
- Per-bit counter cnt (CNT_W bits):
  - If sync_q2 == sw_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: sw_level <= sync_q2, cnt <= 0, and the matching edge strobe is 1 for the next cycle only.
  - Else: cnt <= cnt+1.
- The counter never wraps, because it clears at DEBOUNCE_CYCLES-1.
- Latency: if sw_raw changes and is stable before edge 0, sw_level changes on edge DEBOUNCE_CYCLES+1. Total is 2 synchronizer cycles + DEBOUNCE_CYCLES mismatch cycles, minus the overlap at edge 1.
- Glitch rejection: a mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles resets cnt to 0. sw_level and the strobes are unchanged.
- DEBOUNCE_CYCLES = 1: sw_level follows sync_q2 one cycle later. Strobes still fire.
- Strobe registration: sw_rise, sw_fall and sw_changed are registered in the same edge as the sw_level update, so they are asserted exactly while the new sw_level is first visible.
- Strobe properties:
  - Never both sw_rise and sw_fall for one bit in the same cycle.
  - Bits are independent; several bits may strobe in the same cycle.
- Reset mid-count: the count is discarded and sw_level returns to 0. If sw_raw is still 1 after reset release, a rise strobe fires DEBOUNCE_CYCLES+1 edges after the first non-reset edge.
- No combinational path from sw_raw to any output.

Decomposition:
- No shared package needed; CNT_W is derived locally.
- One sub-module, debounce_bit: a single-bit synchronizer, counter, level and edge logic with the same DEBOUNCE_CYCLES parameter.
- The top instantiates WIDTH copies via generate and ORs the strobes into sw_changed.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and a 100 MHz clock.
1. Reset: RESET=1 for 3 cycles with sw_raw=4'hF -> all outputs 0 throughout reset. After release, sw_level=4'hF appears 5 edges later, with sw_rise=4'hF for exactly 1 cycle.
2. Clean step: sw_raw 4'h0->4'h1 held -> sw_level[0]=1 at edge 5 after the change. sw_rise=4'h1 and sw_changed=1 for 1 cycle; sw_fall stays 0.
3. Glitch: sw_raw[1] high for 3 cycles, then low -> sw_level stays 4'h0 and no strobes. A later 4-cycle high pulse is accepted.
4. Bounce: sw_raw[2] toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one sw_rise[2], 5 edges after the final transition.
5. Multi-bit: sw_raw 4'h5->4'hA simultaneously -> in one cycle, sw_rise=4'hA, sw_fall=4'h5 and sw_changed=1; then sw_level=4'hA.
6. Mid-count reset: RESET asserted 2 cycles into a mismatch on bit 3 -> no strobe during reset. The count restarts after release and the rise fires 5 edges after release.
